// File: rtl/ccff_bitstream_loader_if.sv
// Bitstream word handshake between a word source and the ccff loader.
// Source drives valid/data; loader answers with ready.
interface ccff_bitstream_loader_if #(
  parameter int WORD_W = 8
);
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic              word_ready;

  modport master (
    output word_valid,
    output word_data,
    input  word_ready
  );

  modport slave (
    input  word_valid,
    input  word_data,
    output word_ready
  );
endinterface

// File: rtl/ccff_bitstream_loader.sv
// Serialises bitstream words onto a ccff configuration chain,
// shifting exactly CHAIN_LEN bits per load and folding ccff_tail into parity.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 18,
  parameter int WORD_W    = 8
) (
  input  logic                    prog_clk,
  input  logic                    pReset,
  input  logic                    start,
  ccff_bitstream_loader_if.slave  wif,
  output logic                    ccff_head,
  output logic                    config_enable,
  input  logic                    ccff_tail,
  output logic                    busy,
  output logic                    done,
  output logic                    tail_parity
);

  localparam int RW = $clog2(CHAIN_LEN + 1);
  localparam int IW = $clog2(WORD_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic              par_q, par_d;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (start) begin
          state_d = S_WAIT;
          rem_d   = RW'(CHAIN_LEN);
          par_d   = 1'b0;
        end
      end
      (state_q == S_WAIT): begin
        if (wif.word_valid) begin
          buf_d   = wif.word_data;
          // last word may be partial: shift only what the chain still needs
          cnt_d   = (32'(rem_q) >= WORD_W) ? IW'(WORD_W) : IW'(rem_q);
          state_d = S_SHIFT;
        end
      end
      (state_q == S_SHIFT): begin
        buf_d = buf_q >> 1;
        cnt_d = cnt_q - IW'(1);
        rem_d = rem_q - RW'(1);
        par_d = par_q ^ ccff_tail;
        if (cnt_q == IW'(1)) begin
          state_d = (rem_q == RW'(1)) ? S_DONE : S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
    end
  end

  assign config_enable  = (state_q == S_SHIFT);
  assign ccff_head      = config_enable & buf_q[0];
  assign wif.word_ready = (state_q == S_WAIT);
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign tail_parity    = par_q;

endmodule
